// File: rtl/mul_wb_queue_if.sv
// Bus bundle for the multiplier write-back queue: M5 result input, ROB write port,
// and the stall/error status back to the pipeline.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 5
`endif

interface mul_wb_queue_if #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH
);
    logic                       valid;
    logic [INSTR_TYPE_SZ-1:0]   instruction_type;
    logic [WORD_SIZE-1:0]       pc;
    logic [WORD_SIZE-1:0]       result;
    logic [ROB_ENTRY_WITDH-1:0] rob_id;
    logic                       flush;
    logic                       wb_grant;

    logic                       wb_valid;
    logic [INSTR_TYPE_SZ-1:0]   wb_instruction_type;
    logic [WORD_SIZE-1:0]       wb_pc;
    logic [WORD_SIZE-1:0]       wb_result;
    logic [ROB_ENTRY_WITDH-1:0] wb_rob_id;
    logic                       mul_stall;
    logic                       overflow_err;

    modport slave (
        input  valid, instruction_type, pc, result, rob_id, flush, wb_grant,
        output wb_valid, wb_instruction_type, wb_pc, wb_result, wb_rob_id,
               mul_stall, overflow_err
    );

    modport master (
        output valid, instruction_type, pc, result, rob_id, flush, wb_grant,
        input  wb_valid, wb_instruction_type, wb_pc, wb_result, wb_rob_id,
               mul_stall, overflow_err
    );
endinterface

// File: rtl/mul_wb_queue.sv
// Circular FIFO buffering M5 multiply results until the ROB write port is granted;
// stalls M1 early enough that ops already in M1..M5 always find a free slot.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 5
`endif

module mul_wb_queue #(
    parameter int WORD_SIZE       = `WORD_SIZE,
    parameter int INSTR_TYPE_SZ   = `INSTR_TYPE_SZ,
    parameter int ROB_ENTRY_WITDH = `ROB_ENTRY_WITDH,
    parameter int DEPTH           = 8,
    parameter int STALL_MARGIN    = 5
) (
    input  logic          clk,
    input  logic          reset,
    mul_wb_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] MARGIN_C = CNT_W'(STALL_MARGIN);

    logic [INSTR_TYPE_SZ-1:0]   type_mem [DEPTH];
    logic [WORD_SIZE-1:0]       pc_mem   [DEPTH];
    logic [WORD_SIZE-1:0]       res_mem  [DEPTH];
    logic [ROB_ENTRY_WITDH-1:0] rob_mem  [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             overflow_q;

    logic not_empty;
    logic do_pop;
    logic do_push;
    logic do_drop;

    assign not_empty = (count != '0);
    assign do_pop    = not_empty && bus.wb_grant && !bus.flush;
    assign do_push   = bus.valid && !bus.flush && ((count < DEPTH_C) || do_pop);
    assign do_drop   = bus.valid && !bus.flush && !do_push;

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so they wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (bus.flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (do_pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                if (do_push && !do_pop) begin
                    count <= count + 1'b1;
                end else if (do_pop && !do_push) begin
                    count <= count - 1'b1;
                end
            end
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is never cleared; occupancy is tracked purely by pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            type_mem[wr_ptr] <= bus.instruction_type;
            pc_mem[wr_ptr]   <= bus.pc;
            res_mem[wr_ptr]  <= bus.result;
            rob_mem[wr_ptr]  <= bus.rob_id;
        end
    end

    assign bus.wb_valid            = not_empty;
    assign bus.wb_instruction_type = type_mem[rd_ptr];
    assign bus.wb_pc               = pc_mem[rd_ptr];
    assign bus.wb_result           = res_mem[rd_ptr];
    assign bus.wb_rob_id           = rob_mem[rd_ptr];
    assign bus.mul_stall           = ((DEPTH_C - count) <= MARGIN_C);
    assign bus.overflow_err        = overflow_q;
endmodule

// File: tb/tb_mul_wb_queue.sv
// Self-checking bench for mul_wb_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef INSTR_TYPE_SZ
`define INSTR_TYPE_SZ 4
`endif
`ifndef ROB_ENTRY_WITDH
`define ROB_ENTRY_WITDH 5
`endif

module tb_mul_wb_queue;
    localparam int W            = `WORD_SIZE;
    localparam int IT           = `INSTR_TYPE_SZ;
    localparam int RW           = `ROB_ENTRY_WITDH;
    localparam int DEPTH        = 8;
    localparam int STALL_MARGIN = 5;

    typedef struct packed {
        logic [IT-1:0] typ;
        logic [W-1:0]  pc;
        logic [W-1:0]  res;
        logic [RW-1:0] rob;
    } entry_t;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    entry_t model_q[$];
    logic   model_ovf;

    mul_wb_queue_if #(.WORD_SIZE(W), .INSTR_TYPE_SZ(IT), .ROB_ENTRY_WITDH(RW)) bus ();

    mul_wb_queue #(
        .WORD_SIZE(W), .INSTR_TYPE_SZ(IT), .ROB_ENTRY_WITDH(RW),
        .DEPTH(DEPTH), .STALL_MARGIN(STALL_MARGIN)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compares every DUT output with what the model says the queue holds right now.
    task automatic check_output(input string tag);
        logic   exp_valid;
        logic   exp_stall;
        entry_t head;
        exp_valid = (model_q.size() != 0);
        exp_stall = ((DEPTH - model_q.size()) <= STALL_MARGIN);
        check_bit({tag, ".wb_valid"}, bus.wb_valid, exp_valid);
        check_bit({tag, ".mul_stall"}, bus.mul_stall, exp_stall);
        check_bit({tag, ".overflow_err"}, bus.overflow_err, model_ovf);
        if (exp_valid) begin
            head = model_q[0];
            check_word({tag, ".wb_rob_id"}, W'(bus.wb_rob_id), W'(head.rob));
            check_word({tag, ".wb_result"}, bus.wb_result, head.res);
            check_word({tag, ".wb_pc"}, bus.wb_pc, head.pc);
            check_word({tag, ".wb_instruction_type"}, W'(bus.wb_instruction_type), W'(head.typ));
        end
    endtask

    // Called just after a falling edge: drive one cycle, check, clock it, advance the model.
    task automatic apply_stimulus(input string tag, input logic v, input logic g, input logic f,
                                  input logic [RW-1:0] rob, input logic [W-1:0] res);
        entry_t e;
        logic   pop_now;
        logic   push_now;
        e.typ = IT'($urandom);
        e.pc  = W'($urandom);
        e.res = res;
        e.rob = rob;
        bus.valid            = v;
        bus.wb_grant         = g;
        bus.flush            = f;
        bus.instruction_type = e.typ;
        bus.pc               = e.pc;
        bus.result           = e.res;
        bus.rob_id           = e.rob;
        check_output(tag);
        @(posedge clk);
        pop_now  = (model_q.size() != 0) && g && !f;
        push_now = v && !f && ((model_q.size() < DEPTH) || pop_now);
        if (f) begin
            model_q.delete();
        end else begin
            if (pop_now) void'(model_q.pop_front());
            if (push_now) model_q.push_back(e);
            if (v && !push_now) model_ovf = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic sync_reset();
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.wb_grant = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        @(negedge clk);
        model_q.delete();
        model_ovf = 1'b0;
        reset = 1'b0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        model_ovf = 1'b0;
        reset = 1'b1;
        bus.valid = 1'b0;
        bus.wb_grant = 1'b0;
        bus.flush = 1'b0;
        bus.instruction_type = '0;
        bus.pc = '0;
        bus.result = '0;
        bus.rob_id = '0;
        repeat (2) @(negedge clk);
        check_output("reset");
        reset = 1'b0;

        $display("[TB] single op");
        apply_stimulus("single_push", 1'b1, 1'b1, 1'b0, RW'(3), 32'h0000_0015);
        check_bit("single_valid", bus.wb_valid, 1'b1);
        check_word("single_rob", W'(bus.wb_rob_id), W'(3));
        check_word("single_res", bus.wb_result, 32'h15);
        apply_stimulus("single_pop", 1'b0, 1'b1, 1'b0, '0, '0);
        check_bit("single_empty", bus.wb_valid, 1'b0);

        $display("[TB] fill and overflow");
        for (int i = 0; i < DEPTH; i++) begin
            apply_stimulus("fill", 1'b1, 1'b0, 1'b0, RW'(i), W'($urandom));
            if (i == 1) check_bit("stall_after2", bus.mul_stall, 1'b0);
            if (i == 2) check_bit("stall_after3", bus.mul_stall, 1'b1);
        end
        check_bit("full_no_ovf", bus.overflow_err, 1'b0);
        apply_stimulus("ninth", 1'b1, 1'b0, 1'b0, RW'(9), W'($urandom));
        check_bit("ninth_ovf", bus.overflow_err, 1'b1);
        check_word("ninth_head", W'(bus.wb_rob_id), W'(0));
        apply_stimulus("full_pushpop", 1'b1, 1'b1, 1'b0, RW'(10), W'($urandom));
        check_word("pushpop_head", W'(bus.wb_rob_id), W'(1));
        check_bit("pushpop_stall", bus.mul_stall, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++)
            apply_stimulus("drain", 1'b0, 1'b1, 1'b0, '0, '0);
        check_bit("drained", bus.wb_valid, 1'b0);
        check_bit("ovf_sticky", bus.overflow_err, 1'b1);

        $display("[TB] wrap");
        sync_reset();
        for (int i = 0; i < 20; i++)
            apply_stimulus("wrap", 1'b1, 1'b1, 1'b0, RW'(i), W'($urandom));
        apply_stimulus("wrap_tail", 1'b0, 1'b1, 1'b0, '0, '0);
        check_bit("wrap_no_ovf", bus.overflow_err, 1'b0);

        $display("[TB] flush");
        for (int i = 0; i < 4; i++)
            apply_stimulus("pre_flush", 1'b1, 1'b0, 1'b0, RW'(i + 16), W'($urandom));
        apply_stimulus("flush", 1'b1, 1'b1, 1'b1, RW'(31), W'($urandom));
        check_bit("flush_valid", bus.wb_valid, 1'b0);
        check_bit("flush_stall", bus.mul_stall, 1'b0);
        repeat (3) apply_stimulus("post_flush", 1'b0, 1'b1, 1'b0, '0, '0);

        $display("[TB] async reset");
        for (int i = 0; i < DEPTH + 1; i++)
            apply_stimulus("ar_fill", 1'b1, 1'b0, 1'b0, RW'(i), W'($urandom));
        repeat (3) apply_stimulus("ar_pop", 1'b0, 1'b1, 1'b0, '0, '0);
        check_output("ar_count5");
        bus.valid = 1'b0;
        bus.wb_grant = 1'b0;
        #2 reset = 1'b1;
        #1;
        check_bit("ar_valid", bus.wb_valid, 1'b0);
        check_bit("ar_ovf", bus.overflow_err, 1'b0);
        check_bit("ar_stall", bus.mul_stall, 1'b0);
        model_q.delete();
        model_ovf = 1'b0;
        #1 reset = 1'b0;
        apply_stimulus("ar_push", 1'b1, 1'b0, 1'b0, RW'(30), 32'hCAFE_0001);
        check_bit("ar_first_valid", bus.wb_valid, 1'b1);
        check_word("ar_first_res", bus.wb_result, 32'hCAFE_0001);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            apply_stimulus("rand",
                           $urandom_range(0, 99) < 60,
                           $urandom_range(0, 99) < 45,
                           $urandom_range(0, 99) < 3,
                           RW'($urandom), W'($urandom));
        end
        check_output("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mul_wb_queue.md
MUL_WB_QUEUE -- requirements
Module: mul_wb_queue

Interface
REQ-001 Parameter WORD_SIZE, default `WORD_SIZE, data/PC width.
REQ-002 Parameter INSTR_TYPE_SZ, default `INSTR_TYPE_SZ, instruction-type field width.
REQ-003 Parameter ROB_ENTRY_WITDH, default `ROB_ENTRY_WITDH, ROB tag width.
REQ-004 Parameter DEPTH, default 8, queue entries, power of two, at least 8.
REQ-005 Parameter STALL_MARGIN, default 5, free-entry threshold covering in-flight M1..M5 ops.
REQ-006 clk  in  1  single clock; all state updates on posedge clk.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 valid  in  1  M5 stage result valid (from M4_M5 valid_out).
REQ-009 instruction_type  in  INSTR_TYPE_SZ  M5 instruction type.
REQ-010 pc  in  WORD_SIZE  M5 PC.
REQ-011 result  in  WORD_SIZE  M5 multiply result.
REQ-012 rob_id  in  ROB_ENTRY_WITDH  M5 ROB tag.
REQ-013 flush  in  1  ROB flush; discards every queued and incoming result.
REQ-014 wb_grant  in  1  ROB write port granted to this queue this cycle.
REQ-015 wb_valid  out  1  head entry is present and requesting write-back.
REQ-016 wb_instruction_type, wb_pc, wb_result, wb_rob_id  out  field widths  head-entry fields.
REQ-017 mul_stall  out  1  hold M1 issue; multiplier pipeline must not accept new ops.
REQ-018 overflow_err  out  1  sticky: a valid result arrived while the queue could not take it.

Function
REQ-019 The queue SHALL be a circular FIFO with a write pointer, a read pointer and a count register of $clog2(DEPTH)+1 bits.
REQ-020 A push SHALL occur on a clock edge when valid=1, flush=0, and (count<DEPTH or a pop occurs in the same cycle).
REQ-021 A pop SHALL occur on a clock edge when wb_valid=1, wb_grant=1 and flush=0.
REQ-022 wb_valid SHALL equal (count!=0), and the wb_* fields SHALL drive the entry at the read pointer combinationally.
REQ-023 Latency from a push to wb_valid=1 SHALL be exactly one cycle; there is no same-cycle bypass.
REQ-024 On a simultaneous push and pop, count SHALL remain unchanged and both pointers SHALL advance.
REQ-025 Pointers SHALL wrap from DEPTH-1 to 0 with no skipped or duplicated entry.
REQ-026 wb_grant while count==0 SHALL be ignored: no pointer or count change.
REQ-027 mul_stall SHALL be combinational and high exactly when (DEPTH-count) <= STALL_MARGIN.
REQ-028 When valid=1 and count==DEPTH with no pop, the result SHALL be dropped, state SHALL be unchanged, and overflow_err SHALL be set on that edge.
REQ-029 overflow_err SHALL stay set until reset.
REQ-030 flush=1 SHALL zero count and both pointers on the next edge, SHALL discard valid and wb_grant in that cycle, and SHALL NOT clear overflow_err.
REQ-031 Entries are released by pointer and count only; stored data need not be cleared.
REQ-032 Results SHALL leave in arrival order, with each field unmodified.

Reset
REQ-033 While reset=1, count, both pointers and overflow_err SHALL be 0, independent of clk.
REQ-034 Consequently, during reset wb_valid=0 and mul_stall=0 (given STALL_MARGIN<DEPTH).
REQ-035 Reset asserted mid-operation SHALL discard all queued entries immediately.
REQ-036 The first push SHALL be accepted on the first posedge after reset deasserts.

Verification
REQ-037 Single op: valid=1, rob_id=3, result=0x0000_0015 for one cycle, wb_grant=1 -> next cycle wb_valid=1, wb_rob_id=3, wb_result=0x15; the following cycle wb_valid=0.
REQ-038 Fill: wb_grant=0, push rob_id 0..7 -> mul_stall rises after the 3rd push (count=3, free=5), count=8; a 9th push sets overflow_err and is dropped; then wb_grant=1 drains 0..7 in order.
REQ-039 Full push+pop: count=8, valid=1 and wb_grant=1 together -> count stays 8, the head pops, the new entry is appended at the tail.
REQ-040 Wrap: 20 pushes with wb_grant held high -> 20 outputs in order, no loss, overflow_err=0.
REQ-041 Flush: count=4, flush=1 with valid=1 -> next cycle count=0, wb_valid=0, mul_stall=0, flushed entries never appear on the outputs.
REQ-042 Async reset: with count=5, pulse reset between clock edges -> wb_valid=0 and overflow_err=0 immediately; the first push after release reaches wb_valid one cycle later.
